// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: pc_inc codes, controller state type and vector address helper
package int_ctrl_pkg;
  localparam logic [1:0] PC_INC_NORMAL = 2'd0;
  localparam logic [1:0] PC_INC_BRANCH = 2'd1;
  localparam logic [1:0] PC_INC_JUMP   = 2'd2;
  localparam logic [1:0] PC_INC_STOP   = 2'd3;
  typedef enum logic {INT_IDLE, INT_SERVICE} int_state_t;
  function automatic logic [31:0] vec_addr(logic [31:0] base, logic [31:0] stride, logic [2:0] id);
    return base + stride * {29'd0, id};
  endfunction
endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: controller/pc-side signal bundle of the interrupt controller
interface int_ctrl_if #(parameter int N_IRQ = 4);
  logic [N_IRQ-1:0] irq_req;
  logic mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic eret;
  logic [31:0] inst_pc;
  logic [1:0] pc_inc_in;
  logic [31:0] abs_addr_in;
  logic [1:0] pc_inc_out;
  logic [31:0] abs_addr_out;
  logic [31:0] epc;
  logic irq_active;
  logic [2:0] irq_id;
  logic [N_IRQ-1:0] irq_ack;
  logic [31:0] int_count;
  modport master (
    output irq_req, mask_we, mask_wdata, eret, inst_pc, pc_inc_in, abs_addr_in,
    input pc_inc_out, abs_addr_out, epc, irq_active, irq_id, irq_ack, int_count
  );
  modport slave (
    input irq_req, mask_we, mask_wdata, eret, inst_pc, pc_inc_in, abs_addr_in,
    output pc_inc_out, abs_addr_out, epc, irq_active, irq_id, irq_ack, int_count
  );
endinterface

// File: rtl/int_ctrl_irq_prio_enc.sv
// int_ctrl_irq_prio_enc: lowest-set-index priority encoder over eligible requests
module int_ctrl_irq_prio_enc #(parameter int N_IRQ = 4) (
  input  logic [N_IRQ-1:0] eligible,
  output logic             valid,
  output logic [2:0]       id
);
  // scan downward so the lowest set index is the last one written
  always_comb begin
    id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) if (eligible[i]) id = 3'(i);
    valid = |eligible;
  end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: vectored non-nesting interrupt controller steering pc; INT_CTRL_STAT_EN adds an entry counter
module int_ctrl import int_ctrl_pkg::*; #(
  parameter int          N_IRQ      = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'd4
) (
  input logic clk,
  input logic clr,
  int_ctrl_if.slave bus
);
  localparam logic [N_IRQ-1:0] ONE = 1;
  int_state_t state, state_nxt;
  logic [N_IRQ-1:0] pending, mask, irq_prev, rise, eligible, ack;
  logic [31:0] epc_q;
  logic [2:0] id_q, sel;
  logic sel_valid, take, ret;
  int_ctrl_irq_prio_enc #(.N_IRQ(N_IRQ)) u_enc (.eligible(eligible), .valid(sel_valid), .id(sel));
  assign rise = bus.irq_req & ~irq_prev;
  assign eligible = pending & mask;
  assign take = state == INT_IDLE && sel_valid && bus.pc_inc_in == PC_INC_NORMAL;
  assign ret = state == INT_SERVICE && bus.eret && bus.pc_inc_in != PC_INC_STOP;
  assign ack = take ? ONE << sel : '0;
  assign bus.epc = epc_q;
  assign bus.irq_id = id_q;
  // state register, updated on the same edge as the pc
  always_ff @(negedge clk) state <= clr ? INT_IDLE : state_nxt;
  // enter on a taken interrupt, leave on eret
  always_comb state_nxt = take ? INT_SERVICE : ret ? INT_IDLE : state;
  // override the pc request on entry and on return, otherwise pass through
  always_comb begin
    bus.pc_inc_out = (take || ret) ? PC_INC_JUMP : bus.pc_inc_in;
    bus.abs_addr_out = take ? vec_addr(VEC_BASE, VEC_STRIDE, sel) : ret ? epc_q : bus.abs_addr_in;
    bus.irq_ack = ack;
    bus.irq_active = state == INT_SERVICE;
  end
  // edge capture, pending set/clear (a new edge beats the entry clear), mask and return context
  always_ff @(negedge clk) begin
    if (clr) begin
      pending <= '0;
      mask <= '0;
      irq_prev <= '0;
      epc_q <= '0;
      id_q <= '0;
    end else begin
      irq_prev <= bus.irq_req;
      pending <= (pending & ~ack) | rise;
      if (bus.mask_we) mask <= bus.mask_wdata;
      if (take) begin
        epc_q <= bus.inst_pc + 32'd1;
        id_q <= sel;
      end
    end
  end
`ifdef INT_CTRL_STAT_EN
  logic [31:0] cnt;
  // count interrupt entries
  always_ff @(negedge clk) cnt <= clr ? '0 : take ? cnt + 32'd1 : cnt;
  assign bus.int_count = cnt;
`else
  assign bus.int_count = '0;
`endif
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: randomized scoreboard bench for int_ctrl against a behavioural model
module tb_int_ctrl;
  localparam logic [1:0] N = 2'd0, B = 2'd1, J = 2'd2, S = 2'd3;
  typedef struct packed {
    logic [1:0] inc; logic [31:0] addr; logic [3:0] ack; logic act;
    logic [31:0] epc; logic [2:0] id; logic [31:0] cnt;
  } exp_t;
  logic clk = 0, clr;
  int_ctrl_if #(.N_IRQ(4)) bus();
  int_ctrl #(.N_IRQ(4)) dut (.clk(clk), .clr(clr), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit [3:0] m_pend = 0, m_mask = 0, m_prev = 0;
  bit m_busy = 0;
  bit [31:0] m_epc = 0, m_cnt = 0;
  bit [2:0] m_id = 0;

  task automatic step(input logic [3:0] req, input bit mwe, input logic [3:0] mwd, input bit er,
                      input logic [31:0] ipc, input logic [1:0] inc, input logic [31:0] abs, input bit c);
    exp_t e;
    int sel;
    bit take, ret;
    @(negedge clk); #1;
    bus.irq_req = req; bus.mask_we = mwe; bus.mask_wdata = mwd; bus.eret = er;
    bus.inst_pc = ipc; bus.pc_inc_in = inc; bus.abs_addr_in = abs; clr = c;
    sel = -1;
    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) sel = i;
    take = !m_busy && sel >= 0 && inc == N;
    ret = m_busy && er && inc != S;
    e.inc = (take || ret) ? J : inc;
    e.addr = take ? 32'h100 + 32'(sel) * 32'd4 : ret ? m_epc : abs;
    e.ack = take ? 4'(1 << sel) : 4'd0;
    e.act = m_busy; e.epc = m_epc; e.id = m_id;
`ifdef INT_CTRL_STAT_EN
    e.cnt = m_cnt;
`else
    e.cnt = 0;
`endif
    q.push_back(e);
    if (c) begin
      m_pend = 0; m_mask = 0; m_prev = 0; m_busy = 0; m_epc = 0; m_id = 0; m_cnt = 0;
    end else begin
      if (take) begin
        m_epc = ipc + 1; m_id = 3'(sel); m_pend[sel] = 0; m_busy = 1; m_cnt++;
      end
      if (ret) m_busy = 0;
      m_pend |= req & ~m_prev;
      m_prev = req;
      if (mwe) m_mask = mwd;
    end
  endtask

  task automatic want(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e, got;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {bus.pc_inc_out, bus.abs_addr_out, bus.irq_ack, bus.irq_active, bus.epc, bus.irq_id, bus.int_count};
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL cycle%0d: got inc=%h addr=%h ack=%h act=%h epc=%h id=%h cnt=%h expected inc=%h addr=%h ack=%h act=%h epc=%h id=%h cnt=%h",
                 cyc, got.inc, got.addr, got.ack, got.act, got.epc, got.id, got.cnt,
                 e.inc, e.addr, e.ack, e.act, e.epc, e.id, e.cnt);
      end
    end
  end

  initial begin
    clr = 1;
    bus.irq_req = 0; bus.mask_we = 0; bus.mask_wdata = 0; bus.eret = 0;
    bus.inst_pc = 0; bus.pc_inc_in = N; bus.abs_addr_in = 0;
    step(0, 0, 0, 0, 0, N, 0, 1);
    #1 want("reset_active", 32'(bus.irq_active), 0);
    want("reset_epc", bus.epc, 0);
    step(0, 1, 4'hf, 0, 0, N, 0, 0);
    step(4'b0100, 0, 0, 0, 32'h10, N, 32'h55, 0);
    step(4'b0100, 0, 0, 0, 32'h10, N, 32'h55, 0);
    #1 want("entry_inc", 32'(bus.pc_inc_out), 32'(J));
    want("entry_vec", bus.abs_addr_out, 32'h108);
    want("entry_ack", 32'(bus.irq_ack), 32'h4);
    step(0, 0, 0, 0, 32'h108, N, 0, 0);
    #1 want("svc_epc", bus.epc, 32'h11);
    want("svc_id", 32'(bus.irq_id), 2);
    want("svc_active", 32'(bus.irq_active), 1);
    step(0, 0, 0, 1, 32'h109, N, 0, 0);
    #1 want("eret_vec", bus.abs_addr_out, 32'h11);
    step(0, 0, 0, 0, 32'h11, N, 0, 0);
    #1 want("eret_active", 32'(bus.irq_active), 0);
    step(4'b1010, 0, 0, 0, 32'h20, N, 0, 0);
    step(4'b1010, 0, 0, 0, 32'h20, N, 0, 0);
    #1 want("prio_vec", bus.abs_addr_out, 32'h104);
    step(4'b1010, 0, 0, 1, 32'h104, N, 0, 0);
    step(4'b1010, 0, 0, 0, 32'h21, N, 0, 0);
    #1 want("second_vec", bus.abs_addr_out, 32'h10C);
    step(0, 0, 0, 1, 32'h10C, N, 0, 0);
    step(0, 1, 4'h0, 0, 32'h30, N, 0, 0);
    step(4'b0001, 0, 0, 0, 32'h30, N, 32'h77, 0);
    step(4'b0001, 0, 0, 0, 32'h31, N, 32'h77, 0);
    #1 want("masked_pass", bus.abs_addr_out, 32'h77);
    step(0, 1, 4'h1, 0, 32'h32, N, 32'h78, 0);
    step(0, 0, 0, 0, 32'h33, N, 32'h79, 0);
    #1 want("unmask_vec", bus.abs_addr_out, 32'h100);
    step(0, 1, 4'hf, 1, 32'h100, N, 0, 0);
    step(4'b0100, 0, 0, 0, 32'h40, B, 32'h99, 0);
    step(4'b0100, 0, 0, 0, 32'h41, B, 32'h99, 0);
    #1 want("branch_pass", 32'(bus.pc_inc_out), 32'(B));
    want("branch_noack", 32'(bus.irq_ack), 0);
    step(4'b0100, 0, 0, 0, 32'h42, S, 32'h9a, 0);
    #1 want("stop_pass", 32'(bus.pc_inc_out), 32'(S));
    step(4'b0100, 0, 0, 0, 32'h43, N, 32'h9b, 0);
    #1 want("after_stop_vec", bus.abs_addr_out, 32'h108);
    step(0, 0, 0, 0, 32'h108, N, 0, 0);
    step(4'b0100, 0, 0, 0, 32'h109, N, 0, 0);
    step(0, 0, 0, 0, 32'h10a, N, 0, 1);
    step(0, 0, 0, 0, 32'h50, N, 32'h5, 0);
    #1 want("clr_active", 32'(bus.irq_active), 0);
    want("clr_epc", bus.epc, 0);
    want("clr_pass", bus.abs_addr_out, 32'h5);
    want("clr_cnt", bus.int_count, 0);
    for (int k = 0; k < 3000; k++) begin
      logic [1:0] inc;
      int r = $urandom_range(0, 9);
      inc = r < 6 ? N : r == 6 ? B : r == 7 ? J : S;
      step(4'($urandom), $urandom_range(0, 15) == 0, 4'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0 ? 32'hFFFF_FFFF : $urandom, inc, $urandom,
           $urandom_range(0, 199) == 0);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Vectored interrupt controller that sequences the program counter.
- Sits between the instruction decoder/controller and the pc block.
- Latches edge-triggered interrupt requests, selects the highest-priority unmasked one, and overrides pc_inc/abs_addr to jump to its vector.
- Saves the return address in epc and restores it on eret. Non-nesting: one handler active at a time.

Parameters:
N_IRQ, 4, number of interrupt sources (1..8)
VEC_BASE, 32'h0000_0100, word address of vector 0
VEC_STRIDE, 4, words between consecutive vectors

Ports:
clk  in  1  clock; all state updates on negedge, same edge as pc
clr  in  1  synchronous active-high reset
irq_req  in  N_IRQ  level request lines; rising edge sets pending
mask_we  in  1  write enable for mask register
mask_wdata  in  N_IRQ  new mask; 1 = enabled
eret  in  1  decoded return-from-interrupt for instruction at inst_pc
inst_pc  in  32  pc of executing instruction (pc.current_pc)
pc_inc_in  in  2  controller's pc_inc request
abs_addr_in  in  32  controller's jump target
pc_inc_out  out  2  pc_inc to pc block
abs_addr_out  out  32  abs_addr to pc block
epc  out  32  saved return address
irq_active  out  1  handler in progress
irq_id  out  3  id of serviced source, valid while irq_active
irq_ack  out  N_IRQ  one-hot, one-cycle pulse on entry
int_count  out  32  interrupts taken (see Optional Feature)

Behaviour:
- Reset (clr at negedge): state IDLE; pending, mask, irq_prev, epc, irq_id, int_count = 0; irq_active = 0.
- Edge capture: irq_prev <= irq_req every cycle; rise = irq_req & ~irq_prev; pending |= rise.
- mask_we: mask <= mask_wdata. Masked pending bits stay pending and are taken once unmasked.
- Eligible = pending & mask. Priority: lowest index wins (irq_prio_enc).
- States: IDLE, SERVICE.
- IDLE, take condition: eligible != 0 and pc_inc_in == PC_INC_NORMAL.
  - Combinationally: pc_inc_out = PC_INC_JUMP; abs_addr_out = VEC_BASE + id*VEC_STRIDE (32-bit, wraps mod 2^32); irq_ack[id] = 1.
  - At negedge: epc <= inst_pc + 1; irq_id <= id; clear pending[id]; state -> SERVICE.
- IDLE, no take: pc_inc_out = pc_inc_in; abs_addr_out = abs_addr_in.
  - Interrupts never taken during BRANCH, JUMP or STOP instructions; they wait for the next NORMAL instruction.
- SERVICE: irq_active = 1; pending still accumulates; no entry.
  - If eret: pc_inc_out = PC_INC_JUMP, abs_addr_out = epc; state -> IDLE at negedge.
  - Otherwise pass-through.
- eret in IDLE: ignored, pass-through (controller decides).
- PC_INC_STOP in either state: always passes through; state, epc and pending frozen except edge capture.
- Simultaneous set/clear of the same pending bit in the entry cycle: set wins, so the new edge stays pending.
- eret and a pending eligible irq in the same cycle: eret completes, and entry is evaluated in the next IDLE cycle (one instruction at epc executes first).
- clr mid-SERVICE: immediate return to reset values; no eret needed.
- Latency: request rising edge seen at negedge N → pending at N → vector jump can be driven in cycle N+1 → pc loads vector at negedge N+1.

Optional Feature:
- INT_CTRL_STAT_EN defined: int_count increments by 1 at every entry; wraps at 2^32; cleared by clr.
- Not defined: int_count tied to 32'h0 and its register omitted.

Decomposition:
- Shared package / defines.vh: PC_INC_NORMAL/BRANCH/JUMP/STOP codes (existing); new state enum int_state_t {INT_IDLE, INT_SERVICE}.
- Sub-module irq_prio_enc: N_IRQ-bit eligible vector in → valid + 3-bit lowest-set index out, purely combinational.

Test Plan:
- Reset, mask=4'b1111, irq_req[2] rises, inst_pc=32'h10, pc_inc_in=NORMAL → next cycle pc_inc_out=JUMP, abs_addr_out=32'h108, irq_ack=4'b0100, then epc=32'h11, irq_id=2, irq_active=1.
- In SERVICE, eret=1 → pc_inc_out=JUMP, abs_addr_out=32'h11, irq_active=0 next cycle.
- irq 1 and 3 rise same cycle, mask=4'b1111 → vector 32'h104 taken first. After eret, pending irq3 → 32'h10C on the next NORMAL instruction.
- mask=4'b0000, irq0 rises → no jump, pass-through unchanged. Write mask=4'b0001 → jump to 32'h100 on the following NORMAL cycle.
- Pending irq while pc_inc_in=BRANCH, then STOP → outputs equal inputs, no ack. Next NORMAL → entry.
- clr asserted while in SERVICE with irq2 pending → all outputs zero, pending cleared. With INT_CTRL_STAT_EN, int_count counts 3 entries as 3, then 0 after clr.
